// File: rtl/pc_next_if.sv
// Bus bundle between the PC stage and its surrounding control/datapath.
//   master: drives pc_src, imm, jump_target, reg_target, stall and halt,
//           and receives pc, pc_plus_c, fetch_en, trap, halted
//           (and redirect_cnt when PC_REDIRECT_COUNT_EN is defined).
//   slave : the PC stage side of the same signals.
// Macro PC_REDIRECT_COUNT_EN adds the redirect_cnt signal.
interface pc_next_if #(
  parameter int unsigned AW    = 16,
  parameter int unsigned IMM_W = 8
);
  logic [1:0]       pc_src;
  logic [IMM_W-1:0] imm;
  logic [AW-1:0]    jump_target;
  logic [AW-1:0]    reg_target;
  logic             stall;
  logic             halt;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    pc_plus_c;
  logic             fetch_en;
  logic             trap;
  logic             halted;
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0]      redirect_cnt;
`endif

  modport master (
    output pc_src, imm, jump_target, reg_target, stall, halt,
    input  pc, pc_plus_c, fetch_en, trap, halted
`ifdef PC_REDIRECT_COUNT_EN
    , input redirect_cnt
`endif
  );

  modport slave (
    input  pc_src, imm, jump_target, reg_target, stall, halt,
    output pc, pc_plus_c, fetch_en, trap, halted
`ifdef PC_REDIRECT_COUNT_EN
    , output redirect_cnt
`endif
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the architectural PC, selects the next PC
// from sequential / branch / jump / jump-register sources, and handles
// stall, halt and misaligned-target traps. Drives instruction-fetch enable.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : pc_next_if slave modport
//             in : pc_src[1:0], imm[IMM_W-1:0], jump_target, reg_target,
//                  stall, halt
//             out: pc (reg), pc_plus_c (comb), fetch_en (reg), trap (reg),
//                  halted (reg), redirect_cnt[15:0] (reg, optional)
// Optional macro PC_REDIRECT_COUNT_EN adds the saturating redirect counter.
module pc_next_unit #(
  parameter int unsigned    AW          = 16,
  parameter int unsigned    INSTR_BYTES = 2,
  parameter int unsigned    IMM_W       = 8,
  parameter logic [AW-1:0]  RESET_VEC   = AW'(16'h0000),
  parameter logic [AW-1:0]  TRAP_VEC    = AW'(16'h0010)
) (
  input  logic   clock,
  input  logic   reset_n,
  pc_next_if.slave bus
);

  localparam int unsigned SH = (INSTR_BYTES == 4) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc_q;
  logic          fetch_en_q;
  logic          trap_q;
  logic          halted_q;

  logic [AW-1:0] pc_plus;
  logic [AW-1:0] imm_sext;
  logic [AW-1:0] next_pc;
  logic          misaligned;

  // Sequential/link value; all arithmetic wraps modulo 2^AW.
  assign pc_plus  = pc_q + AW'(INSTR_BYTES);
  assign imm_sext = {{(AW-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

  // Next-PC source select.
  always_comb begin
    next_pc = pc_plus;
    unique case (bus.pc_src)
      2'b00: next_pc = pc_plus;
      2'b01: next_pc = pc_plus + (imm_sext << SH);
      2'b10: next_pc = bus.jump_target;
      2'b11: next_pc = bus.reg_target;
      default: next_pc = pc_plus;
    endcase
  end

  assign misaligned = |next_pc[SH-1:0];

  // Control FSM with registered PC, fetch enable, trap and halted flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc_q       <= RESET_VEC;
      fetch_en_q <= 1'b0;
      trap_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state      <= RUN;
          fetch_en_q <= 1'b1;
          trap_q     <= 1'b0;
        end
        RUN: begin
          if (bus.stall) begin
            // Halt is deliberately ignored while stalled.
            trap_q <= 1'b0;
          end else if (bus.halt) begin
            state      <= HALT;
            fetch_en_q <= 1'b0;
            halted_q   <= 1'b1;
            trap_q     <= 1'b0;
          end else if (misaligned) begin
            pc_q   <= TRAP_VEC;
            trap_q <= 1'b1;
          end else begin
            pc_q   <= next_pc;
            trap_q <= 1'b0;
          end
        end
        HALT: begin
          fetch_en_q <= 1'b0;
          halted_q   <= 1'b1;
          trap_q     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          fetch_en_q <= 1'b0;
          trap_q     <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] redirect_cnt_q;

  // Counts accepted non-sequential redirects (traps included), saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      redirect_cnt_q <= 16'd0;
    end else if (state == RUN && !bus.stall && !bus.halt &&
                 bus.pc_src != 2'b00 && redirect_cnt_q != 16'hFFFF) begin
      redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
`endif

  assign bus.pc        = pc_q;
  assign bus.pc_plus_c = pc_plus;
  assign bus.fetch_en  = fetch_en_q;
  assign bus.trap      = trap_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Testbench for pc_next_unit: directed scenarios plus randomized stimulus
// compared against a behavioural model of the PC stage.
module tb_pc_next_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned IMM_W = 8;
  localparam int IB = 2;
  localparam int RESET_V = 'h0000;
  localparam int TRAP_V  = 'h0010;

  logic clock;
  logic reset_n;

  pc_next_if #(.AW(AW), .IMM_W(IMM_W)) bus ();

  pc_next_unit #(
    .AW(AW), .INSTR_BYTES(IB), .IMM_W(IMM_W),
    .RESET_VEC(16'h0000), .TRAP_VEC(16'h0010)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: 0 = idle, 1 = running, 2 = halted.
  int m_mode;
  int m_pc;
  int m_trap;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RESET_V; m_trap = 0; m_cnt = 0;
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_edge();
    int nxt;
    if (m_mode == 0) begin
      m_mode = 1; m_trap = 0;
    end else if (m_mode == 1) begin
      if (bus.stall) m_trap = 0;
      else if (bus.halt) begin m_mode = 2; m_trap = 0; end
      else begin
        case (bus.pc_src)
          2'd0: nxt = m_pc + IB;
          2'd1: nxt = m_pc + IB + int'($signed(bus.imm)) * IB;
          2'd2: nxt = int'(bus.jump_target);
          default: nxt = int'(bus.reg_target);
        endcase
        nxt = nxt & 'hFFFF;
        if (nxt % IB != 0) begin m_pc = TRAP_V; m_trap = 1; end
        else begin m_pc = nxt; m_trap = 0; end
        if (bus.pc_src != 2'd0 && m_cnt < 'hFFFF) m_cnt++;
      end
    end else begin
      m_trap = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
    check({tag, ".pc_plus"}, 32'(bus.pc_plus_c), 32'((m_pc + IB) & 'hFFFF));
    check({tag, ".fetch_en"}, 32'(bus.fetch_en), 32'(m_mode == 1));
    check({tag, ".trap"}, 32'(bus.trap), 32'(m_trap));
    check({tag, ".halted"}, 32'(bus.halted), 32'(m_mode == 2));
`ifdef PC_REDIRECT_COUNT_EN
    check({tag, ".redirect_cnt"}, 32'(bus.redirect_cnt), 32'(m_cnt));
`endif
  endtask

  // Advance one edge, update the model, sample 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic [1:0] src, input logic [7:0] imm,
                       input logic [15:0] jt, input logic [15:0] rt,
                       input logic st, input logic ht);
    bus.pc_src = src; bus.imm = imm; bus.jump_target = jt;
    bus.reg_target = rt; bus.stall = st; bus.halt = ht;
  endtask

  // Reset applied between edges and released before the next one.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(2'd0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    model_reset();
    #12;
    compare_all("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Reset then sequential run: 0000 (idle), 0000, 0002, 0004, 0006.
    compare_all("idle");
    check("idle.fetch_en_low", 32'(bus.fetch_en), 32'd0);
    step("seq0");
    step("seq1");
    step("seq2");
    step("seq3");
    check("seq.pc_0006", 32'(bus.pc), 32'h0006);

    // Backward branch: 0006 + 2 - 6 = 0002.
    drive(2'd1, 8'hFD, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step("br_back");
    check("br_back.pc_0002", 32'(bus.pc), 32'h0002);

    // Wrap: jump to FFFE then branch +0x7F instructions -> 00FE.
    drive(2'd2, 8'h00, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    step("jmp_fffe");
    drive(2'd1, 8'h7F, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step("br_wrap");
    check("br_wrap.pc_00fe", 32'(bus.pc), 32'h00FE);

    // Jump, misaligned jump-register trap, then sequential recovery.
    drive(2'd2, 8'h00, 16'h0040, 16'h0000, 1'b0, 1'b0);
    step("jmp_40");
    check("jmp.pc_0040", 32'(bus.pc), 32'h0040);
    drive(2'd3, 8'h00, 16'h0000, 16'h0043, 1'b0, 1'b0);
    step("jr_trap");
    check("jr_trap.pc_0010", 32'(bus.pc), 32'h0010);
    check("jr_trap.trap_1", 32'(bus.trap), 32'd1);
    drive(2'd0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step("after_trap");
    check("after_trap.pc_0012", 32'(bus.pc), 32'h0012);
    check("after_trap.trap_0", 32'(bus.trap), 32'd0);

    // Back-to-back traps keep trap high.
    drive(2'd2, 8'h00, 16'h0101, 16'h0000, 1'b0, 1'b0);
    step("trap_a");
    step("trap_b");
    check("trap_b.trap_1", 32'(bus.trap), 32'd1);

    // Stall dominates halt, then halt freezes everything.
    drive(2'd2, 8'h00, 16'h0200, 16'h0000, 1'b1, 1'b1);
    step("stall_halt0");
    step("stall_halt1");
    check("stall_halt.halted_0", 32'(bus.halted), 32'd0);
    drive(2'd0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step("halt");
    check("halt.halted_1", 32'(bus.halted), 32'd1);
    drive(2'd2, 8'h00, 16'h0300, 16'h0000, 1'b0, 1'b0);
    step("halt_jmp");
    check("halt_jmp.pc_0010", 32'(bus.pc), 32'h0010);
    do_reset("halt_reset");
    check("halt_reset.halted_0", 32'(bus.halted), 32'd0);

    // Async reset mid-run from PC=0040.
    drive(2'd0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step("r_idle");
    drive(2'd2, 8'h00, 16'h0040, 16'h0000, 1'b0, 1'b0);
    step("r_jmp");
    check("r_jmp.pc_0040", 32'(bus.pc), 32'h0040);
    do_reset("async_reset");
    check("async_reset.pc_0000", 32'(bus.pc), 32'h0000);

    // Redirect counting: 3 jumps, 1 stalled jump, 1 trap -> 4.
    step("c_idle");
    drive(2'd2, 8'h00, 16'h0020, 16'h0000, 1'b0, 1'b0); step("c_j0");
    drive(2'd2, 8'h00, 16'h0030, 16'h0000, 1'b0, 1'b0); step("c_j1");
    drive(2'd2, 8'h00, 16'h0050, 16'h0000, 1'b1, 1'b0); step("c_stall");
    drive(2'd2, 8'h00, 16'h0060, 16'h0000, 1'b0, 1'b0); step("c_j2");
    drive(2'd3, 8'h00, 16'h0000, 16'h0071, 1'b0, 1'b0); step("c_trap");
`ifdef PC_REDIRECT_COUNT_EN
    check("cnt.equals_4", 32'(bus.redirect_cnt), 32'd4);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] jt, rt;
      jt = 16'($urandom);
      rt = 16'($urandom);
      if ($urandom_range(3) != 0) jt[0] = 1'b0;
      if ($urandom_range(3) != 0) rt[0] = 1'b0;
      drive(2'($urandom), 8'($urandom), jt, rt,
            $urandom_range(4) == 0, $urandom_range(40) == 0);
      step("rand");
      if (m_mode == 2 && $urandom_range(3) == 0) do_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
